// File: rtl/freelist_mp.sv
// Multi-port circular free list of physical register tags with per-branch read-pointer checkpoints.
// Optional checkpoint storage is built only when FREELIST_CKPT_EN is defined.
module freelist_mp #(
  parameter int NUM_ARCH = 32,
  parameter int NUM_PHYS = 64,
  parameter int TAG_W    = 6,
  parameter int ALLOC_W  = 2,
  parameter int FREE_W   = 2,
  parameter int NUM_CKPT = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [$clog2(ALLOC_W+1)-1:0]         alloc_cnt,
  output logic                                 alloc_gnt,
  output logic [ALLOC_W*TAG_W-1:0]             alloc_tag,
  input  logic [FREE_W-1:0]                    free_vld,
  input  logic [FREE_W*TAG_W-1:0]              free_tag,
  input  logic                                 ckpt_save,
  input  logic                                 ckpt_restore,
  input  logic [$clog2(NUM_CKPT)-1:0]          ckpt_id,
  output logic [$clog2(NUM_PHYS-NUM_ARCH):0]   free_cnt,
  output logic                                 empty,
  output logic                                 full,
  output logic                                 overflow_err
);

  localparam int NUM_FREE = NUM_PHYS - NUM_ARCH;
  localparam int PTR_W    = $clog2(NUM_FREE);
  localparam int CNT_W    = PTR_W + 1;

  logic [TAG_W-1:0] fifo [NUM_FREE];
  logic [CNT_W-1:0] rd_ptr, wr_ptr, rd_next, rd_load, gnt_cnt, room, wr_cnt;
  logic [FREE_W-1:0] wr_en;
  logic [PTR_W-1:0] wr_idx [FREE_W];
  logic             drop;
  logic             restore_act;

  assign free_cnt = wr_ptr - rd_ptr;
  assign empty    = (free_cnt == '0);
  assign full     = (free_cnt == CNT_W'(NUM_FREE));
  assign room     = CNT_W'(NUM_FREE) - free_cnt;

  assign alloc_gnt = (alloc_cnt != '0) && (free_cnt >= CNT_W'(alloc_cnt)) && !restore_act;
  assign gnt_cnt   = alloc_gnt ? CNT_W'(alloc_cnt) : '0;
  assign rd_next   = rd_ptr + gnt_cnt;

  always_comb begin
    alloc_tag = '0;
    for (int k = 0; k < ALLOC_W; k++) begin
      alloc_tag[k*TAG_W +: TAG_W] = fifo[PTR_W'(rd_ptr + CNT_W'(k))];
    end
  end

  // Compact valid free lanes onto consecutive slots; capacity is judged on pre-edge occupancy.
  always_comb begin
    wr_cnt = '0;
    drop   = 1'b0;
    wr_en  = '0;
    for (int i = 0; i < FREE_W; i++) begin
      wr_idx[i] = '0;
      if (free_vld[i]) begin
        if (wr_cnt < room) begin
          wr_en[i]  = 1'b1;
          wr_idx[i] = PTR_W'(wr_ptr + wr_cnt);
          wr_cnt    = wr_cnt + CNT_W'(1);
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

`ifdef FREELIST_CKPT_EN
  logic [CNT_W-1:0] ckpt_ptr [NUM_CKPT];

  assign restore_act = ckpt_restore;
  assign rd_load     = ckpt_ptr[ckpt_id];

  // A snapshot captures the pointer after this cycle's grant; restore overrides a same-cycle save.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CKPT; i++) ckpt_ptr[i] <= '0;
    end else if (ckpt_save && !ckpt_restore) begin
      ckpt_ptr[ckpt_id] <= rd_next;
    end
  end
`else
  logic unused_ckpt;

  assign restore_act = 1'b0;
  assign rd_load     = rd_next;
  assign unused_ckpt = ^{ckpt_save, ckpt_restore, ckpt_id};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= CNT_W'(NUM_FREE);
      overflow_err <= 1'b0;
    end else begin
      rd_ptr <= restore_act ? rd_load : rd_next;
      wr_ptr <= wr_ptr + wr_cnt;
      if (drop) overflow_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FREE; i++) fifo[i] <= TAG_W'(NUM_ARCH + i);
    end else begin
      for (int i = 0; i < FREE_W; i++) begin
        if (wr_en[i]) fifo[wr_idx[i]] <= free_tag[i*TAG_W +: TAG_W];
      end
    end
  end

endmodule

// File: tb/tb_freelist_mp.sv
// Bench for freelist_mp: vector table, directed corner sequences and a queue-based random reference.
module tb_freelist_mp;
  localparam int NUM_ARCH = 32, NUM_PHYS = 64, TAG_W = 6;
  localparam int ALLOC_W = 2, FREE_W = 2, NUM_CKPT = 4, NUM_FREE = 32;
`ifdef FREELIST_CKPT_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  alloc_cnt;
  logic        alloc_gnt;
  logic [11:0] alloc_tag;
  logic [1:0]  free_vld;
  logic [11:0] free_tag;
  logic        ckpt_save, ckpt_restore;
  logic [1:0]  ckpt_id;
  logic [5:0]  free_cnt;
  logic        empty, full, overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  freelist_mp #(.NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS), .TAG_W(TAG_W), .ALLOC_W(ALLOC_W),
                .FREE_W(FREE_W), .NUM_CKPT(NUM_CKPT)) dut (
    .clk(clk), .rst(rst), .alloc_cnt(alloc_cnt), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .free_vld(free_vld), .free_tag(free_tag), .ckpt_save(ckpt_save), .ckpt_restore(ckpt_restore),
    .ckpt_id(ckpt_id), .free_cnt(free_cnt), .empty(empty), .full(full), .overflow_err(overflow_err));

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cnt, input int vld, input int t0, input int t1,
                       input bit sv, input bit rs, input int id);
    alloc_cnt    = 2'(cnt);
    free_vld     = 2'(vld);
    free_tag     = {6'(t1), 6'(t0)};
    ckpt_save    = sv;
    ckpt_restore = rs;
    ckpt_id      = 2'(id);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    rst = 1'b0;
  endtask

  // Reference: every tag ever returned kept in arrival order; head counts tags handed out.
  int hist[$];
  int head;
  int ck[NUM_CKPT];
  bit movf;

  function automatic void m_reset();
    hist.delete();
    for (int i = 0; i < NUM_FREE; i++) hist.push_back(NUM_ARCH + i);
    head = 0;
    movf = 1'b0;
    for (int i = 0; i < NUM_CKPT; i++) ck[i] = 0;
  endfunction

  function automatic int m_avail();
    return hist.size() - head;
  endfunction

  function automatic bit m_gnt(input int cnt, input bit rs);
    return (cnt != 0) && (m_avail() >= cnt) && !(rs && CK_EN);
  endfunction

  function automatic void m_update(input int cnt, input int vld, input int t0, input int t1,
                                   input bit sv, input bit rs, input int id);
    int new_head, room, written;
    new_head = head + (m_gnt(cnt, rs) ? cnt : 0);
    room     = NUM_FREE - m_avail();
    written  = 0;
    for (int i = 0; i < FREE_W; i++) begin
      if (vld[i]) begin
        if (written < room) begin
          hist.push_back(i == 0 ? t0 : t1);
          written++;
        end else movf = 1'b1;
      end
    end
    if (CK_EN && rs) head = ck[id];
    else begin
      head = new_head;
      if (CK_EN && sv) ck[id] = new_head;
    end
  endfunction

  typedef struct {
    int cnt; int vld; int t0; int t1;
    bit gnt; int tag0; int tag1; int fc; bit emp; bit ful; bit ovf;
  } vec_t;

  vec_t tbl[6];

  initial begin
    // Consecutive cycles from reset; expected outputs are those seen before each edge.
    tbl[0] = '{0, 0, 0, 0,   1'b0, 32, 33, 32, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{0, 3, 5, 6,   1'b0, 32, 33, 32, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{2, 0, 0, 0,   1'b1, 32, 33, 32, 1'b0, 1'b1, 1'b1};
    tbl[3] = '{1, 0, 0, 0,   1'b1, 34, 35, 30, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{2, 2, 7, 40,  1'b1, 35, 36, 29, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{0, 1, 9, 0,   1'b0, 37, 38, 28, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;

    for (int r = 0; r < 6; r++) begin
      drive(tbl[r].cnt, tbl[r].vld, tbl[r].t0, tbl[r].t1, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", r),   alloc_gnt,       tbl[r].gnt);
      chk($sformatf("tbl%0d_tag0", r),  alloc_tag[5:0],  tbl[r].tag0);
      chk($sformatf("tbl%0d_tag1", r),  alloc_tag[11:6], tbl[r].tag1);
      chk($sformatf("tbl%0d_fcnt", r),  free_cnt,        tbl[r].fc);
      chk($sformatf("tbl%0d_empty", r), empty,           tbl[r].emp);
      chk($sformatf("tbl%0d_full", r),  full,            tbl[r].ful);
      chk($sformatf("tbl%0d_ovf", r),   overflow_err,    tbl[r].ovf);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("tbl_end_fcnt", free_cnt, 29);

    // Drain the whole list two at a time, then the list is empty.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(2, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("drain%0d_gnt", i),  alloc_gnt,       1);
      chk($sformatf("drain%0d_tag0", i), alloc_tag[5:0],  32 + 2*i);
      chk($sformatf("drain%0d_tag1", i), alloc_tag[11:6], 33 + 2*i);
      step();
    end
    @(negedge clk);
    chk("drain17_gnt", alloc_gnt, 0);
    chk("drain17_empty", empty, 1);
    chk("drain17_fcnt", free_cnt, 0);
    step();

    // Partial availability never grants; a same-cycle free is not bypassed.
    drive(0, 1, 50, 0, 0, 0, 0);
    step();
    drive(2, 2, 0, 40, 0, 0, 0);
    @(negedge clk);
    chk("partial_fcnt", free_cnt, 1);
    chk("partial_gnt", alloc_gnt, 0);
    step();
    drive(2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_fcnt", free_cnt, 2);
    chk("wrap_gnt", alloc_gnt, 1);
    chk("wrap_tag0", alloc_tag[5:0], 50);
    chk("wrap_tag1", alloc_tag[11:6], 40);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("wrap_after_empty", empty, 1);

    // Overflow on a full list is sticky and leaves the count alone.
    do_reset();
    drive(0, 3, 1, 2, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    @(negedge clk);
    chk("ovf_flag", overflow_err, 1);
    chk("ovf_fcnt", free_cnt, 32);
    chk("ovf_full", full, 1);

    // Save after two allocations, allocate four more, then restore.
    do_reset();
    drive(2, 0, 0, 0, 1, 0, 1);
    @(negedge clk);
    chk("ck_tag0", alloc_tag[5:0], 32);
    chk("ck_tag1", alloc_tag[11:6], 33);
    step();
    drive(2, 0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(0, 0, 0, 0, 0, 1, 1);
    step();
    drive(2, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ck_fcnt", free_cnt, CK_EN ? 30 : 26);
    chk("ck_gnt", alloc_gnt, 1);
    chk("ck_tag0_after", alloc_tag[5:0], CK_EN ? 34 : 38);
    chk("ck_tag1_after", alloc_tag[11:6], CK_EN ? 35 : 39);
    step();

    // Restore blocks a same-cycle allocation but a same-cycle free still lands.
    do_reset();
    drive(2, 0, 0, 0, 1, 0, 2);
    step();
    drive(2, 0, 0, 0, 0, 0, 0);
    step();
    drive(2, 1, 10, 0, 0, 1, 2);
    @(negedge clk);
    chk("rsfree_gnt", alloc_gnt, CK_EN ? 0 : 1);
    step();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rsfree_fcnt", free_cnt, CK_EN ? 31 : 27);

    // Random traffic against the queue reference, with occasional mid-run resets.
    do_reset();
    m_reset();
    for (int c = 0; c < 3000; c++) begin
      int cnt, vld, t0, t1, bias, fc;
      bit r;
      bias = ((c / 250) % 2 == 0) ? 70 : 25;
      cnt  = ($urandom_range(99) < bias) ? $urandom_range(2, 1) : 0;
      vld  = $urandom_range(3);
      if ($urandom_range(99) < bias) vld = vld & 1;
      t0   = $urandom_range(63);
      t1   = $urandom_range(63);
      r    = ($urandom_range(299) == 0);
      rst  = r;
      drive(cnt, vld, t0, t1, 0, 0, 0);
      @(negedge clk);
      fc = m_avail();
      chk("rnd_gnt", alloc_gnt, m_gnt(cnt, 0));
      chk("rnd_fcnt", free_cnt, fc);
      chk("rnd_empty", empty, fc == 0);
      chk("rnd_full", full, fc == NUM_FREE);
      chk("rnd_ovf", overflow_err, movf);
      for (int k = 0; k < ALLOC_W; k++) begin
        if (k < cnt && k < fc) chk("rnd_tag", alloc_tag[k*TAG_W +: TAG_W], hist[head + k]);
      end
      if (r) m_reset();
      else m_update(cnt, vld, t0, t1, 0, 0, 0);
      step();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/freelist_mp.md
# freelist_mp

Multi-port circular free list for physical register tags in the out-of-order rename stage. It supports up to ALLOC_W allocations and FREE_W frees per cycle, which makes it suitable for superscalar rename and commit. It also keeps per-branch snapshots of the read pointer, so a mispredict rolls back speculative allocations in one cycle. It sits between rename, which allocates, and the ROB commit port, which frees previous mappings.

## Interface
Parameters:
- NUM_ARCH, default 32: architectural registers. Tags 0..NUM_ARCH-1 are never in the list at reset.
- NUM_PHYS, default 64: physical registers. NUM_FREE = NUM_PHYS-NUM_ARCH, which must be a power of 2 and ≥ ALLOC_W.
- TAG_W, default 6: tag width, equal to clog2(NUM_PHYS).
- ALLOC_W, default 2: allocation lanes.
- FREE_W, default 2: free lanes.
- NUM_CKPT, default 4: checkpoint slots. CKPT_W = clog2(NUM_CKPT).

Ports (PTR_W = clog2(NUM_FREE); CNT_W = PTR_W+1):
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alloc_cnt  in  clog2(ALLOC_W+1)  number of tags requested this cycle (0..ALLOC_W).
- alloc_gnt  out  1  request granted (all-or-nothing).
- alloc_tag  out  ALLOC_W*TAG_W  lane k = bits [k*TAG_W +: TAG_W] = fifo[rd+k].
- free_vld  in  FREE_W  per-lane free valid; any bit pattern is legal.
- free_tag  in  FREE_W*TAG_W  per-lane tags being returned.
- ckpt_save  in  1  snapshot the read pointer into slot ckpt_id.
- ckpt_restore  in  1  restore the read pointer from slot ckpt_id.
- ckpt_id  in  CKPT_W  slot for save or restore.
- free_cnt  out  CNT_W  tags currently available.
- empty  out  1  free_cnt == 0.
- full  out  1  free_cnt == NUM_FREE.
- overflow_err  out  1  sticky flag: a free was dropped because the list was full.

## Operation
- Storage: fifo[0..NUM_FREE-1] of TAG_W bits.
- Pointers rd_ptr and wr_ptr are CNT_W bits wide; the MSB is the wrap bit. free_cnt = wr_ptr - rd_ptr, modulo 2^CNT_W. Entries are indexed by the low PTR_W bits, so wrap-around is natural.
- Reset sets:
  - fifo[i] = NUM_ARCH+i
  - rd_ptr = 0, wr_ptr = NUM_FREE (wrap bit 1)
  - free_cnt = NUM_FREE, full = 1, empty = 0, overflow_err = 0
  - all checkpoint slots = 0
  - alloc_gnt = 0 while alloc_cnt = 0
- Alloc:
  - alloc_gnt = (alloc_cnt != 0) && (free_cnt >= alloc_cnt) && !ckpt_restore.
  - alloc_tag is always driven from the current state; only lanes 0..alloc_cnt-1 are meaningful.
  - On grant, rd_ptr += alloc_cnt. A partial grant is never given.
- Free:
  - Valid lanes are compacted in lane order. The j-th set bit of free_vld is written to fifo[wr_ptr+j], and wr_ptr advances by popcount(free_vld).
  - Capacity check uses free_cnt before the edge; this cycle's allocations are not credited.
  - Lanes beyond NUM_FREE - free_cnt are dropped, and overflow_err is set until reset.
- Same-cycle alloc and free: both apply. Next free_cnt = free_cnt - granted + written. A freed tag is not visible to alloc until the next cycle (no bypass).
- Checkpoint save: slot ckpt_id stores the post-update rd_ptr, i.e. rd_ptr plus this cycle's granted count.
- Checkpoint restore:
  - rd_ptr is loaded from slot ckpt_id.
  - Allocation is blocked that cycle.
  - Frees in the same cycle still apply.
  - If save and restore are both asserted, restore wins and the save is ignored.
- Restore correctness relies on frees coming only from commit, which is older than any live checkpoint. The block does not check this.

## Timing
- Alloc and free are single-cycle operations; the outputs are combinational from registered state.
- alloc_tag and alloc_gnt are valid in the same cycle as alloc_cnt; pointers update at the next rising edge.
- free_cnt, empty and full reflect the edge results one cycle after the request.
- Restore takes effect at the edge. Allocation can resume the following cycle with the rolled-back free_cnt.
- rst asserted mid-operation overrides all requests in that cycle.

## Configuration
- FREELIST_CKPT_EN defined:
  - checkpoint storage and logic are present, as described above.
- Not defined:
  - the ckpt_save, ckpt_restore and ckpt_id ports still exist but are ignored;
  - no checkpoint registers are built;
  - alloc_gnt drops the !ckpt_restore term.

## Test plan
- Reset then alloc_cnt=2 each cycle for 16 cycles -> tags 32,33,…,63 in order; on the 17th cycle alloc_gnt=0, empty=1.
- free_cnt=1, alloc_cnt=2 -> alloc_gnt=0, rd_ptr unchanged. Same cycle free_vld=2'b10 with tag 40 -> next cycle free_cnt=2 and alloc_cnt=2 is granted with lane1 tag 40 at the wrapped index.
- full=1, free_vld=2'b11 -> both lanes dropped, overflow_err=1 and stays set; free_cnt stays 32.
- After reset, alloc 2 tags (32,33) with ckpt_save id 1. Then alloc 4 more and restore id 1 -> free_cnt=30 and the next alloc returns 34,35.
- Restore while alloc_cnt=2 and free_vld=2'b01 -> alloc_gnt=0 and the free is still written.
- Build without FREELIST_CKPT_EN; repeat the restore scenario -> the restore is ignored and allocations continue from the current rd_ptr.
